// File: rtl/uart_tx_frame.sv
// UART transmit framer: serializes a captured word as start, data (LSB first),
// optional parity and one or two stop bits, advancing one bit per baud_clk rising edge.
module uart_tx_frame #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  baud_clk,
    input  logic                  send,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [1:0]            parity_type,
    input  logic                  stop_bits,
    output logic                  tx_out,
    output logic                  busy,
    output logic                  done
);
    localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WAIT   = 3'd1;
    localparam logic [2:0] S_START  = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_PARITY = 3'd4;
    localparam logic [2:0] S_STOP1  = 3'd5;
    localparam logic [2:0] S_STOP2  = 3'd6;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    logic [2:0]            state_q, state_d;
    logic                  baud_q;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  par_en_q, par_en_d;
    logic                  par_bit_q, par_bit_d;
    logic                  stop2_q, stop2_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  tick;

    // One bit period per rising edge of the sampled baud square wave.
    assign tick = baud_clk & ~baud_q;

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        stop2_d   = stop2_q;
        tx_d      = tx_q;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (send) begin
                    shift_d   = data_in;
                    par_en_d  = (parity_type == 2'b01) || (parity_type == 2'b10);
                    par_bit_d = parity_type[0] ? ~^data_in : ^data_in;
                    stop2_d   = stop_bits;
                    cnt_d     = '0;
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                if (tick) begin
                    tx_d    = 1'b0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (tick) begin
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                    cnt_d   = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (tick) begin
                    if (cnt_q == LAST_BIT) begin
                        if (par_en_q) begin
                            tx_d    = par_bit_q;
                            state_d = S_PARITY;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = S_STOP1;
                        end
                    end else begin
                        tx_d    = shift_q[0];
                        shift_d = shift_q >> 1;
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_PARITY: begin
                if (tick) begin
                    tx_d    = 1'b1;
                    state_d = S_STOP1;
                end
            end
            S_STOP1: begin
                if (tick) begin
                    if (stop2_q) begin
                        state_d = S_STOP2;
                    end else begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            S_STOP2: begin
                if (tick) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            baud_q    <= 1'b0;
            shift_q   <= '0;
            cnt_q     <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            stop2_q   <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_clk;
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            stop2_q   <= stop2_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign tx_out = tx_q;
    assign busy   = busy_q;
    assign done   = done_q;
endmodule
